// File: rtl/reset_sequencer.sv
// Releases downstream reset domains in ascending order, each after a fixed gap, then waits for that domain's ready with a timeout.
// Latency: the first release comes RELEASE_GAP edges after GAP entry; each later release comes RELEASE_GAP edges after the previous ack. All outputs are registered.
// Backpressure: a missing domain ready stalls the sequence until ACK_TIMEOUT, then the block latches an error; a soft request unwinds the domains in reverse order.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int RELEASE_GAP = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iPorReset,
    input  logic                   iSoftReq,
    input  logic [NUM_DOMAINS-1:0] iDomainReady,
    output logic [NUM_DOMAINS-1:0] oDomainReset,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oTimeoutErr,
    output logic [3:0]             oFailIdx
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_GAP,
        S_WAIT,
        S_DONE,
        S_ERROR,
        S_SHUT
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_DOMAINS - 1);

    state_t                 state, stateNext;
    logic [3:0]             idx, idxNext;
    logic [3:0]             ptr, ptrNext;
    logic [CNT_W-1:0]       cnt, cntNext;
    logic [NUM_DOMAINS-1:0] rstNext;
    logic                   errNext;
    logic [3:0]             failNext;
    logic                   readySel;

    // Loop-based select keeps the 4-bit index legal for any NUM_DOMAINS.
    always_comb begin
        readySel = 1'b0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx == 4'(k)) readySel = iDomainReady[k];
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        ptrNext   = ptr;
        cntNext   = cnt;
        rstNext   = oDomainReset;
        errNext   = oTimeoutErr;
        failNext  = oFailIdx;

        if (iPorReset) begin
            stateNext = S_HOLD;
            rstNext   = '1;
            idxNext   = '0;
            cntNext   = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    stateNext = S_GAP;
                    rstNext   = '1;
                    idxNext   = '0;
                    cntNext   = '0;
                    errNext   = 1'b0;
                    failNext  = '0;
                end
                S_GAP: begin
                    if (iSoftReq) begin
                        if (idx == 4'd0) begin
                            stateNext = S_HOLD;
                            rstNext   = '1;
                        end else begin
                            stateNext = S_SHUT;
                            ptrNext   = idx - 4'd1;
                        end
                    end else if (cnt == GAP_LAST) begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (idx == 4'(k)) rstNext[k] = 1'b0;
                        end
                        cntNext   = '0;
                        stateNext = S_WAIT;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (iSoftReq) begin
                        stateNext = S_SHUT;
                        ptrNext   = idx;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                        if (readySel) begin
                            if (idx == IDX_LAST) begin
                                stateNext = S_DONE;
                            end else begin
                                idxNext   = idx + 4'd1;
                                cntNext   = '0;
                                stateNext = S_GAP;
                            end
                        end else if (cnt == TO_LAST) begin
                            stateNext = S_ERROR;
                            errNext   = 1'b1;
                            failNext  = idx;
                            rstNext   = '1;
                        end
                    end
                end
                S_DONE: begin
                    if (iSoftReq) begin
                        stateNext = S_SHUT;
                        ptrNext   = IDX_LAST;
                    end
                end
                S_ERROR: begin
                    if (iSoftReq) stateNext = S_HOLD;
                end
                S_SHUT: begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (ptr == 4'(k)) rstNext[k] = 1'b1;
                    end
                    if (ptr == 4'd0) stateNext = S_HOLD;
                    else             ptrNext   = ptr - 4'd1;
                end
                default: begin
                    stateNext = S_HOLD;
                    rstNext   = '1;
                    idxNext   = '0;
                    cntNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state        <= S_HOLD;
            idx          <= '0;
            ptr          <= '0;
            cnt          <= '0;
            oDomainReset <= '1;
            oBusy        <= 1'b1;
            oDone        <= 1'b0;
            oTimeoutErr  <= 1'b0;
            oFailIdx     <= '0;
        end else begin
            state        <= stateNext;
            idx          <= idxNext;
            ptr          <= ptrNext;
            cnt          <= cntNext;
            oDomainReset <= rstNext;
            oBusy        <= !(stateNext == S_DONE || stateNext == S_ERROR);
            oDone        <= (stateNext == S_DONE);
            oTimeoutErr  <= errNext;
            oFailIdx     <= failNext;
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the chip-level power-on reset and releases a set of downstream reset domains one at a time, in index order.
- A fixed gap precedes each release; after each release the block waits for that domain's ready acknowledge, with a timeout.
- A software reset request re-asserts the domains in reverse order, then the release sequence restarts.
- Sits between the power-on reset generator and the subsystem reset inputs.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset domains (1..16).
- RELEASE_GAP, 16, cycles from the start of the GAP state to deassertion of the current domain reset (>=1).
- ACK_TIMEOUT, 1024, maximum cycles to wait for a domain's ready after its release (>=2).
- CNT_W, 16, width of the gap/timeout counter; must hold max(RELEASE_GAP, ACK_TIMEOUT).

Ports:
- iClock  input  1  system clock.
- iReset  input  1  synchronous, active-high block reset.
- iPorReset  input  1  upstream power-on reset, active-high, synchronous to iClock.
- iSoftReq  input  1  software reset request, level, sampled each edge.
- iDomainReady  input  NUM_DOMAINS  per-domain ready acknowledge; bit k is only meaningful while waiting on domain k.
- oDomainReset  output  NUM_DOMAINS  per-domain reset, active-high.
- oBusy  output  1  sequencer not in DONE or ERROR.
- oDone  output  1  all domains released and acknowledged.
- oTimeoutErr  output  1  sticky ack-timeout flag.
- oFailIdx  output  4  index of the domain that timed out.

Behaviour:
- Reset values (iReset=1 at an edge): state=HOLD, oDomainReset=all 1s, idx=0, cnt=0, oBusy=1, oDone=0, oTimeoutErr=0, oFailIdx=0. iReset overrides all other inputs.
- Priority at every edge: iReset > iPorReset > iSoftReq > iDomainReady > timeout.
- All outputs are registered.
- HOLD: all domain resets asserted.
  - While iPorReset=1, stay in HOLD.
  - On sampling iPorReset=0: go to GAP with cnt=0, idx=0, and clear oTimeoutErr and oFailIdx.
- GAP:
  - cnt increments each edge.
  - At the edge where cnt==RELEASE_GAP-1: oDomainReset[idx]<=0, cnt<=0, go to WAIT.
  - Result: domain idx deasserts exactly RELEASE_GAP edges after GAP entry.
- WAIT: cnt increments each edge.
  - If iDomainReady[idx]=1 and idx==NUM_DOMAINS-1: go to DONE.
  - If iDomainReady[idx]=1 and idx<NUM_DOMAINS-1: idx++, cnt=0, go to GAP.
  - Else if cnt==ACK_TIMEOUT-1: go to ERROR, oTimeoutErr<=1, oFailIdx<=idx, all oDomainReset<=1.
  - If ready and the timeout terminal count occur on the same edge, ready wins.
  - Ready is checked from the first edge after release; already-high ready is accepted then (1-cycle minimum).
- DONE: oDone=1, oBusy=0. Resets stay released.
- ERROR: all resets asserted, oBusy=0, oDone=0. oTimeoutErr and oFailIdx hold.
  - iSoftReq=1 goes to HOLD (error cleared on leaving HOLD).
  - iPorReset=1 goes to HOLD.
- iPorReset=1 in GAP, WAIT or DONE: next edge sets all resets to 1, idx=0, state HOLD, oDone=0. No reverse sequence.
- iSoftReq=1 in GAP, WAIT or DONE: go to SHUT with ptr = highest released index.
  - WAIT(idx) gives ptr=idx; DONE gives ptr=NUM_DOMAINS-1; GAP(idx) gives ptr=idx-1.
  - GAP with idx=0 (nothing released) goes directly to HOLD.
- SHUT: each edge sets oDomainReset[ptr]<=1.
  - If ptr==0, go to HOLD; else ptr--.
  - iSoftReq and iDomainReady are ignored in SHUT.
  - Exactly one domain re-asserts per cycle, highest index first.
- iSoftReq in HOLD or SHUT has no effect. iSoftReq held high through HOLD does not retrigger until the sequence leaves HOLD.
- oBusy=1 in HOLD, GAP, WAIT, SHUT.
- No domain reset deasserts except in GAP at terminal count. Release order is strictly ascending; re-assert order in SHUT is strictly descending.
- Counter width is CNT_W. The counter never wraps because the terminal compare always fires first.

Test Plan (NUM_DOMAINS=4, RELEASE_GAP=4, ACK_TIMEOUT=32 unless stated):
- Nominal release: drop iPorReset at edge E, each ready returns 2 cycles after its reset falls -> oDomainReset goes 1111→1110 at E+4, →1100 at E+4+2+4, …; oDone=1 after domain 3 ack; oBusy=0.
- Timeout: domain 2 ready never rises -> 32 cycles after oDomainReset[2] falls: oTimeoutErr=1, oFailIdx=2, oDomainReset=1111, oBusy=0; then pulse iSoftReq -> HOLD, flag clears on GAP entry, full release completes.
- Soft reset from DONE: iSoftReq=1 for 1 cycle -> oDomainReset goes 0000→1000→1100→1110→1111 on consecutive edges, then release restarts with first deassert 4 edges later.
- Soft reset mid-WAIT on domain 1 -> oDomainReset goes 1100→1110→1111 on two edges, then HOLD.
- iPorReset reasserted in WAIT on domain 2 -> next edge oDomainReset=1111, oDone=0, state HOLD; ready inputs ignored while iPorReset=1.
- Simultaneous events: in WAIT, iDomainReady and iSoftReq high on the same edge -> SHUT wins. Ready rising on the exact timeout terminal edge -> accepted, no error. iReset asserted during SHUT -> all reset values next edge.
